// File: rtl/config_mem_pkg.sv
// Shared types and sizing helpers for the configuration memory loader.
package config_mem_pkg;

    // Default width of one bitstream word.
    localparam int BYTE_W_DEFAULT = 8;

    // Loader phases: collect words, publish them atomically, then hold.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_APPLY = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Number of bitstream words needed to cover num_mem configuration bits.
    function automatic int nwords(input int num_mem, input int byte_w);
        return (num_mem + byte_w - 1) / byte_w;
    endfunction

endpackage

// File: rtl/config_mem_loader_if.sv
// Bitstream handshake between a configuration source and the loader.
interface config_mem_loader_if
    import config_mem_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEFAULT
);

    logic              cfg_start;
    logic [BYTE_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (
        output cfg_start,
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_start,
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );

endinterface

// File: rtl/config_mem_loader.sv
// Loads NUM_MEM configuration bits from an MSB-first word stream into a
// shadow register and publishes them to mem/mem_inv in a single edge, so the
// mux primitives never see a partial or inconsistent configuration.
// The interface instance must use the same BYTE_W as this module.
module config_mem_loader
    import config_mem_pkg::*;
#(
    parameter int NUM_MEM = 5,
    parameter int BYTE_W  = BYTE_W_DEFAULT
) (
    input  logic               prog_clk,
    input  logic               prog_reset_n,
    config_mem_loader_if.slave cfg,
    output logic [NUM_MEM-1:0] mem,
    output logic [NUM_MEM-1:0] mem_inv,
    output logic               cfg_done,
    output logic               cfg_err
);

    localparam int                NWORDS    = nwords(NUM_MEM, BYTE_W);
    localparam int                CNT_W     = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(NWORDS - 1);

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [NUM_MEM-1:0] shadow_q,  shadow_d;
    logic [NUM_MEM-1:0] mem_q,     mem_d;
    logic [NUM_MEM-1:0] mem_inv_q, mem_inv_d;
    logic               done_q,    done_d;
    logic               err_q,     err_d;

    logic restart;
    logic xfer;

    // Low bits of the final word may fall beyond NUM_MEM and are dropped.
    logic unused_data;
    assign unused_data = ^cfg.cfg_data;

    // A start pulse is honoured everywhere except during the one-cycle APPLY.
    assign restart = cfg.cfg_start && (state_q != ST_APPLY);

    // A word moves only while LOAD is advertised through cfg_ready.
    assign xfer = cfg.cfg_valid && (state_q == ST_LOAD);

    // Next-state logic: word assembly, counter, publish and status flags.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        mem_d     = mem_q;
        mem_inv_d = mem_inv_q;
        done_d    = done_q;
        err_d     = err_q;

        if (restart) begin
            // Fresh load: drop any partial shadow but keep the live outputs.
            state_d  = ST_LOAD;
            cnt_d    = '0;
            shadow_d = '0;
            done_d   = 1'b0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_LOAD: begin
                    if (xfer) begin
                        // Stream bit k sits at position BYTE_W-1-(k%BYTE_W)
                        // of word k/BYTE_W.
                        for (int k = 0; k < NUM_MEM; k++) begin
                            if (cnt_q == CNT_W'(k / BYTE_W)) begin
                                shadow_d[k] = cfg.cfg_data[BYTE_W-1-(k % BYTE_W)];
                            end
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_WORD) begin
                            state_d = ST_APPLY;
                        end
                    end
                end
                ST_APPLY: begin
                    mem_d     = shadow_q;
                    mem_inv_d = ~shadow_q;
                    state_d   = ST_DONE;
                end
                ST_DONE: begin
                    done_d = 1'b1;
                    if (cfg.cfg_valid) begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            // NOTE: the shadow is a plain register bank, not RAM, so it is
            // reset along with everything else and a reset mid-load cannot
            // leak stale bits into the next load.
            shadow_q  <= '0;
            mem_q     <= '0;
            mem_inv_q <= '1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed by the combinational block.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            mem_q     <= mem_d;
            mem_inv_q <= mem_inv_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cfg.cfg_ready = (state_q == ST_LOAD);
    assign mem           = mem_q;
    assign mem_inv       = mem_inv_q;
    assign cfg_done      = done_q;
    assign cfg_err       = err_q;

endmodule

// File: tb/tb_config_mem_loader.sv
// Bench for config_mem_loader: three instances (NUM_MEM = 5, 8, 12) driven by
// directed vectors, a per-cycle compare against a stream-level model, and a
// set of hand-computed literal expectations.
module tb_config_mem_loader;

    localparam int NM[3] = '{5, 8, 12};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       i_start[3];
    logic       i_valid[3];
    logic [7:0] i_data[3];
    bit         chk_en = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    config_mem_loader_if #(.BYTE_W(8)) if5 ();
    config_mem_loader_if #(.BYTE_W(8)) if8 ();
    config_mem_loader_if #(.BYTE_W(8)) if12 ();

    assign if5.cfg_start  = i_start[0];
    assign if5.cfg_valid  = i_valid[0];
    assign if5.cfg_data   = i_data[0];
    assign if8.cfg_start  = i_start[1];
    assign if8.cfg_valid  = i_valid[1];
    assign if8.cfg_data   = i_data[1];
    assign if12.cfg_start = i_start[2];
    assign if12.cfg_valid = i_valid[2];
    assign if12.cfg_data  = i_data[2];

    logic [4:0]  mem5,  inv5;
    logic [7:0]  mem8,  inv8;
    logic [11:0] mem12, inv12;
    logic        done5, done8, done12, err5, err8, err12;

    config_mem_loader #(.NUM_MEM(5), .BYTE_W(8)) dut5 (
        .prog_clk(clk), .prog_reset_n(rst_n), .cfg(if5),
        .mem(mem5), .mem_inv(inv5), .cfg_done(done5), .cfg_err(err5)
    );
    config_mem_loader #(.NUM_MEM(8), .BYTE_W(8)) dut8 (
        .prog_clk(clk), .prog_reset_n(rst_n), .cfg(if8),
        .mem(mem8), .mem_inv(inv8), .cfg_done(done8), .cfg_err(err8)
    );
    config_mem_loader #(.NUM_MEM(12), .BYTE_W(8)) dut12 (
        .prog_clk(clk), .prog_reset_n(rst_n), .cfg(if12),
        .mem(mem12), .mem_inv(inv12), .cfg_done(done12), .cfg_err(err12)
    );

    logic [63:0] a_mem[3], a_inv[3];
    logic        a_done[3], a_err[3], a_rdy[3];
    assign a_mem[0] = 64'(mem5);   assign a_inv[0] = 64'(inv5);
    assign a_mem[1] = 64'(mem8);   assign a_inv[1] = 64'(inv8);
    assign a_mem[2] = 64'(mem12);  assign a_inv[2] = 64'(inv12);
    assign a_done[0] = done5;  assign a_err[0] = err5;  assign a_rdy[0] = if5.cfg_ready;
    assign a_done[1] = done8;  assign a_err[1] = err8;  assign a_rdy[1] = if8.cfg_ready;
    assign a_done[2] = done12; assign a_err[2] = err12; assign a_rdy[2] = if12.cfg_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stream-level model ----------------
    // Words collected so far are kept as a list; the configuration is the
    // first NM bits of their MSB-first concatenation.
    bit          m_load[3], m_apply[3], m_indone[3], m_done[3], m_err[3];
    logic [63:0] m_mem[3];
    logic [7:0]  m_buf[3][2];
    int          m_cnt[3];

    function automatic logic [63:0] assemble(input int nm, input logic [7:0] w0, input logic [7:0] w1);
        logic [15:0] stream;
        logic [63:0] r;
        stream = {w0, w1};
        r = '0;
        for (int k = 0; k < nm; k++) r[k] = stream[15-k];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_load[i] <= 1'b0; m_apply[i] <= 1'b0; m_indone[i] <= 1'b0;
                m_done[i] <= 1'b0; m_err[i]   <= 1'b0; m_cnt[i]    <= 0;
                m_mem[i]  <= '0;
            end else if (m_apply[i]) begin
                m_mem[i]    <= assemble(NM[i], m_buf[i][0], m_buf[i][1]);
                m_apply[i]  <= 1'b0;
                m_indone[i] <= 1'b1;
            end else if (i_start[i]) begin
                m_load[i]   <= 1'b1;
                m_cnt[i]    <= 0;
                m_err[i]    <= 1'b0;
                m_done[i]   <= 1'b0;
                m_indone[i] <= 1'b0;
                m_buf[i][0] <= '0;
                m_buf[i][1] <= '0;
            end else if (m_load[i] && i_valid[i]) begin
                m_buf[i][m_cnt[i]] <= i_data[i];
                m_cnt[i] <= m_cnt[i] + 1;
                if (m_cnt[i] + 1 == (NM[i] + 7) / 8) begin
                    m_load[i]  <= 1'b0;
                    m_apply[i] <= 1'b1;
                end
            end else if (m_indone[i]) begin
                m_done[i] <= 1'b1;
                if (i_valid[i]) m_err[i] <= 1'b1;
            end
        end
    end

    // Per-cycle compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic [63:0] mask;
                mask = (64'd1 << NM[i]) - 64'd1;
                check($sformatf("dut%0d mem", NM[i]),     a_mem[i], m_mem[i]);
                check($sformatf("dut%0d mem_inv", NM[i]), a_inv[i], ~m_mem[i] & mask);
                check($sformatf("dut%0d done", NM[i]),    64'(a_done[i]), 64'(m_done[i]));
                check($sformatf("dut%0d err", NM[i]),     64'(a_err[i]),  64'(m_err[i]));
                check($sformatf("dut%0d ready", NM[i]),   64'(a_rdy[i]),  64'(m_load[i]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_start[i] = 1'b0; i_valid[i] = 1'b0; i_data[i] = 8'h00;
        end
        cyc(); cyc(); cyc();
        chk_en = 1'b1;
        check("reset mem5",     64'(mem5), 64'h00);
        check("reset inv5",     64'(inv5), 64'h1F);
        check("reset inv12",    64'(inv12), 64'hFFF);
        check("reset done5",    64'(done5), 64'd0);
        check("reset ready5",   64'(if5.cfg_ready), 64'd0);

        // NUM_MEM=5: start in the first cycle after reset, word 0xA8.
        rst_n = 1'b1; i_start[0] = 1'b1;
        cyc();
        i_start[0] = 1'b0; i_valid[0] = 1'b1; i_data[0] = 8'hA8;
        check("load ready5", 64'(if5.cfg_ready), 64'd1);
        cyc();
        i_valid[0] = 1'b0;
        check("mem5 held during apply", 64'(mem5), 64'h00);
        cyc();
        check("mem5 applied",  64'(mem5), 64'h15);
        check("inv5 applied",  64'(inv5), 64'h0A);
        check("done5 not yet", 64'(done5), 64'd0);
        cyc();
        check("done5 risen",   64'(done5), 64'd1);

        // Stray valid in DONE sets the sticky error; start clears it.
        i_valid[0] = 1'b1;
        cyc();
        i_valid[0] = 1'b0;
        check("err5 set",       64'(err5), 64'd1);
        check("mem5 unchanged", 64'(mem5), 64'h15);
        cyc();
        check("err5 sticky",    64'(err5), 64'd1);
        i_start[0] = 1'b1;
        cyc();
        i_start[0] = 1'b0;
        check("err5 cleared",   64'(err5), 64'd0);
        check("done5 cleared",  64'(done5), 64'd0);

        // NUM_MEM=8: start together with valid 0x55 must not transfer it.
        i_start[1] = 1'b1; i_valid[1] = 1'b1; i_data[1] = 8'h55;
        cyc();
        i_start[1] = 1'b0; i_data[1] = 8'hC5;
        cyc();
        i_valid[1] = 1'b0;
        cyc();
        check("mem8 first word after start", 64'(mem8), 64'hA3);

        // Load 0xFF, then restart and stall before sending 0x00.
        cyc();
        i_start[1] = 1'b1;
        cyc();
        i_start[1] = 1'b0; i_valid[1] = 1'b1; i_data[1] = 8'hFF;
        cyc();
        i_valid[1] = 1'b0;
        cyc(); cyc();
        check("mem8 all ones", 64'(mem8), 64'hFF);
        i_start[1] = 1'b1;
        cyc();
        i_start[1] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            cyc();
            check("mem8 held while stalled", 64'(mem8), 64'hFF);
            check("ready8 while stalled",    64'(if8.cfg_ready), 64'd1);
        end
        i_valid[1] = 1'b1; i_data[1] = 8'h00;
        cyc();
        i_valid[1] = 1'b0;
        check("mem8 old until apply", 64'(mem8), 64'hFF);
        cyc();
        check("mem8 zero", 64'(mem8), 64'h00);
        check("inv8 ones", 64'(inv8), 64'hFF);

        // NUM_MEM=12: two words, low nibble of the second ignored.
        i_start[2] = 1'b1;
        cyc();
        i_start[2] = 1'b0; i_valid[2] = 1'b1; i_data[2] = 8'h12;
        cyc();
        i_data[2] = 8'h3F;
        cyc();
        i_valid[2] = 1'b0;
        cyc();
        check("mem12 two words", 64'(mem12), 64'hC48);
        check("inv12 two words", 64'(inv12), 64'h3B7);
        cyc();
        check("done12", 64'(done12), 64'd1);

        // Reset after the first of two words.
        i_start[2] = 1'b1;
        cyc();
        i_start[2] = 1'b0; i_valid[2] = 1'b1; i_data[2] = 8'h12;
        cyc();
        i_valid[2] = 1'b0; rst_n = 1'b0;
        cyc();
        check("mem12 after reset",   64'(mem12), 64'h000);
        check("inv12 after reset",   64'(inv12), 64'hFFF);
        check("ready12 after reset", 64'(if12.cfg_ready), 64'd0);
        rst_n = 1'b1;
        cyc();
        check("ready12 idle", 64'(if12.cfg_ready), 64'd0);
        i_start[2] = 1'b1;
        cyc();
        i_start[2] = 1'b0; i_valid[2] = 1'b1; i_data[2] = 8'hAB;
        cyc();
        i_data[2] = 8'hCD;
        cyc();
        // Start during APPLY is ignored.
        i_valid[2] = 1'b0; i_start[2] = 1'b1;
        cyc();
        i_start[2] = 1'b0;
        check("mem12 reload",    64'(mem12), 64'h3D5);
        check("done12 not yet",  64'(done12), 64'd0);
        cyc();
        check("done12 reload",   64'(done12), 64'd1);
        cyc(); cyc();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
